// File: rtl/sseg_capture.sv
// Receive-side monitor for a multiplexed 4-digit seven-segment bus: synchronizes pins, waits for a stable slot, decodes the glyph.
// Optional `SSEG_CAP_ERR_EN adds the err pulse for multi-anode slots and unknown glyphs.
module sseg_capture #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       seg_a,
    input  logic       seg_b,
    input  logic       seg_c,
    input  logic       seg_d,
    input  logic       seg_e,
    input  logic       seg_f,
    input  logic       seg_g,
    input  logic [3:0] an,
    output logic [4:0] out0,
    output logic [4:0] out1,
    output logic [4:0] out2,
    output logic [4:0] out3,
    output logic [3:0] digit_valid,
    output logic       upd_stb,
    output logic [1:0] upd_idx,
    output logic       frame_done
`ifdef SSEG_CAP_ERR_EN
    , output logic     err
`endif
);
    localparam logic [7:0] SAT_COUNT    = 8'(STABLE_CYCLES);
    localparam logic [7:0] ACCEPT_COUNT = 8'(STABLE_CYCLES - 2);

    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b1000000: return 5'd0;
            7'b1111001: return 5'd1;
            7'b0100100: return 5'd2;
            7'b0110000: return 5'd3;
            7'b0011001: return 5'd4;
            7'b0010010: return 5'd5;
            7'b0000010: return 5'd6;
            7'b1111000: return 5'd7;
            7'b0000000: return 5'd8;
            7'b0010000: return 5'd9;
            7'b0001000: return 5'd10;
            7'b0000011: return 5'd11;
            7'b1000110: return 5'd12;
            7'b0100001: return 5'd13;
            7'b0000110: return 5'd14;
            7'b0001110: return 5'd15;
            7'b1111111: return 5'd31;
            default:    return 5'd30;
        endcase
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] low);
        if (low[0])      return 2'd0;
        else if (low[1]) return 2'd1;
        else if (low[2]) return 2'd2;
        else             return 2'd3;
    endfunction

    logic [10:0] pins, sync1, s, s_prev;
    logic [7:0]  count;
    logic [4:0]  digits [4];

    logic       stable, window_end, single_low, multi_low;
    logic [3:0] an_low, next_valid;
    logic [1:0] idx;
    logic [4:0] glyph;

    assign pins       = {an, seg_g, seg_f, seg_e, seg_d, seg_c, seg_b, seg_a};
    assign stable     = (s == s_prev);
    // The counter moves to STABLE_CYCLES-1 on this edge, so the accept happens exactly once per window.
    assign window_end = stable && (count == ACCEPT_COUNT);
    assign an_low     = ~s[10:7];
    assign single_low = $onehot(an_low);
    assign multi_low  = $countones(an_low) > 1;
    assign idx        = low_index(an_low);
    assign glyph      = decode(s[6:0]);
    assign next_valid = digit_valid | (4'b0001 << idx);

    assign out0 = digits[0];
    assign out1 = digits[1];
    assign out2 = digits[2];
    assign out3 = digits[3];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // Synchronizer resets to the idle bus (all lines high), which is a blank slot and never accepted.
            sync1       <= '1;
            s           <= '1;
            s_prev      <= '1;
            count       <= '0;
            // NOTE: the digit registers are plain flops, so they take a reset value like every other register.
            for (int i = 0; i < 4; i++) digits[i] <= 5'd31;
            digit_valid <= '0;
            upd_stb     <= 1'b0;
            upd_idx     <= 2'd0;
            frame_done  <= 1'b0;
`ifdef SSEG_CAP_ERR_EN
            err         <= 1'b0;
`endif
        end else begin
            sync1  <= pins;
            s      <= sync1;
            s_prev <= s;

            if (!stable)                count <= '0;
            else if (count != SAT_COUNT) count <= count + 8'd1;

            upd_stb    <= 1'b0;
            frame_done <= 1'b0;
            if (window_end && single_low) begin
                digits[idx] <= glyph;
                upd_stb     <= 1'b1;
                upd_idx     <= idx;
                if (next_valid == 4'b1111) begin
                    frame_done  <= 1'b1;
                    digit_valid <= 4'b0000;
                end else begin
                    digit_valid <= next_valid;
                end
            end

`ifdef SSEG_CAP_ERR_EN
            err <= window_end && ((single_low && glyph == 5'd30) || multi_low);
`endif
        end
    end
endmodule

// File: tb/tb_sseg_capture.sv
// Scoreboard bench for sseg_capture: a run-length model predicts each accepted slot; a monitor checks every output pulse.
module tb_sseg_capture;
    localparam int STABLE = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] seg_v = 7'h7f;
    logic [3:0] an    = 4'hf;
    logic [4:0] out0, out1, out2, out3;
    logic [3:0] digit_valid;
    logic       upd_stb, frame_done, err_w;
    logic [1:0] upd_idx;

    sseg_capture #(.STABLE_CYCLES(STABLE)) dut (
        .clock(clock), .reset(reset),
        .seg_a(seg_v[0]), .seg_b(seg_v[1]), .seg_c(seg_v[2]), .seg_d(seg_v[3]),
        .seg_e(seg_v[4]), .seg_f(seg_v[5]), .seg_g(seg_v[6]),
        .an(an),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .digit_valid(digit_valid), .upd_stb(upd_stb), .upd_idx(upd_idx),
        .frame_done(frame_done)
`ifdef SSEG_CAP_ERR_EN
        , .err(err_w)
`endif
    );
`ifndef SSEG_CAP_ERR_EN
    assign err_w = 1'b0;
`endif

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int cyc; bit upd; int idx; int code; bit fd; bit er; int dv;
    } evt_t;
    evt_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    endtask

    // Reference model: glyph table indexed by code, plus per-digit state.
    logic [6:0] glyph_of [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    int m_out [4] = '{31, 31, 31, 31};
    int m_dv = 0;
    logic [10:0] prev_val = 11'h7ff;

    function automatic int model_decode(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (glyph_of[i] == p) return i;
        return (p == 7'h7f) ? 31 : 30;
    endfunction

    function automatic int out_sel(input int i);
        case (i)
            0: return int'(out0);
            1: return int'(out1);
            2: return int'(out2);
            default: return int'(out3);
        endcase
    endfunction

    // Predict the response to one held slot: a value held at least STABLE clocks is accepted
    // STABLE+2 clocks after it appears on the pins.
    task automatic predict(input logic [3:0] a, input logic [6:0] sg, input int dur, input int c);
        evt_t e;
        int lows, k;
        if (dur < STABLE) return;
        lows = 0; k = 0;
        for (int i = 3; i >= 0; i--) if (!a[i]) begin lows++; k = i; end
        e.cyc = c + STABLE + 2; e.idx = k; e.code = 0; e.fd = 0; e.er = 0; e.dv = m_dv;
        if (lows == 1) begin
            e.upd = 1;
            e.code = model_decode(sg);
            e.er = (e.code == 30);
            m_out[k] = e.code;
            m_dv = m_dv | (1 << k);
            if (m_dv == 15) begin e.fd = 1; m_dv = 0; end
            e.dv = m_dv;
            sb.push_back(e);
        end else if (lows > 1) begin
`ifdef SSEG_CAP_ERR_EN
            e.upd = 0; e.er = 1;
            sb.push_back(e);
`endif
        end
    endtask

    // Called at a falling edge: drive a slot and hold it for dur clocks.
    task automatic hold(input logic [3:0] a, input logic [6:0] sg, input int dur);
        an = a; seg_v = sg;
        predict(a, sg, dur, cyc);
        prev_val = {a, sg};
        repeat (dur) @(negedge clock);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * STABLE && sb.size() != 0; i++) @(negedge clock);
        check("scoreboard_drained", sb.size(), 0);
    endtask

    // Monitor: every output pulse must match the head of the scoreboard, on the predicted clock.
    always @(negedge clock) begin
        if (!reset && (upd_stb || frame_done || err_w)) begin
            check("pending_event", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                evt_t e;
                e = sb.pop_front();
                check("event_cycle", cyc, e.cyc);
                check("upd_stb", upd_stb, e.upd);
                check("frame_done", frame_done, e.fd);
`ifdef SSEG_CAP_ERR_EN
                check("err", err_w, e.er);
`endif
                if (e.upd) begin
                    check("upd_idx", upd_idx, e.idx);
                    check("out_code", out_sel(e.idx), e.code);
                    check("digit_valid", digit_valid, e.dv);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_out0"}, out0, 31);
        check({tag, "_out1"}, out1, 31);
        check({tag, "_out2"}, out2, 31);
        check({tag, "_out3"}, out3, 31);
        check({tag, "_digit_valid"}, digit_valid, 0);
        check({tag, "_upd_stb"}, upd_stb, 0);
        check({tag, "_upd_idx"}, upd_idx, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_err"}, err_w, 0);
    endtask

    initial begin
        logic [3:0] a;
        logic [6:0] sg;
        repeat (3) @(negedge clock);
        check_reset_state("reset");
        reset = 1'b0;
        @(negedge clock);

        // Single digit: glyph 3 on digit 0.
        hold(4'b1110, 7'b0110000, 40);
        check("single_out0", out0, 3);
        check("single_valid", digit_valid, 1);

        // Full frame: 1, 2, A, F on digits 0..3.
        hold(4'b1110, glyph_of[1], 20);
        hold(4'b1101, glyph_of[2], 20);
        hold(4'b1011, glyph_of[10], 20);
        hold(4'b0111, glyph_of[15], 20);
        repeat (4) @(negedge clock);
        check("frame_out0", out0, 1);
        check("frame_out1", out1, 2);
        check("frame_out2", out2, 10);
        check("frame_out3", out3, 15);
        check("frame_valid_cleared", digit_valid, 0);

        // Glitch rejection on digit 1.
        hold(4'b1101, glyph_of[5], 20);
        hold(4'b1101, 7'b0000000, 10);
        hold(4'b1101, glyph_of[5], 20);
        check("glitch_out1", out1, 5);

        // Blank slot, then an unknown glyph, then a multi-anode slot.
        hold(4'b1111, 7'b1111111, 40);
        hold(4'b1011, 7'b1010101, 20);
        check("unknown_out2", out2, 30);
        hold(4'b1100, glyph_of[8], 40);
        drain();

        // Randomized slots, including durations around the STABLE boundary.
        for (int n = 0; n < 150; n++) begin
            int r, d;
            do begin
                r = $urandom_range(0, 9);
                if (r < 6)      a = 4'b1111 & ~(4'b0001 << $urandom_range(0, 3));
                else if (r < 8) a = 4'b1111;
                else            a = 4'($urandom_range(0, 15));
                r = $urandom_range(0, 15);
                if (r < 12)      sg = glyph_of[$urandom_range(0, 15)];
                else if (r == 12) sg = 7'h7f;
                else             sg = 7'($urandom_range(0, 127));
            end while ({a, sg} == prev_val);
            d = (n % 5 == 0) ? $urandom_range(STABLE - 1, STABLE) : $urandom_range(3, 30);
            hold(a, sg, d);
        end
        drain();
        check("final_out0", out0, m_out[0]);
        check("final_out1", out1, m_out[1]);
        check("final_out2", out2, m_out[2]);
        check("final_out3", out3, m_out[3]);
        check("final_valid", digit_valid, m_dv);

        // Reset 8 clocks into a stable window, then a full window after release.
        if ({4'b1110, glyph_of[3]} == prev_val) hold(4'b1111, 7'h7f, 4);
        an = 4'b1110; seg_v = glyph_of[3];
        repeat (8) @(negedge clock);
        reset = 1'b1;
        #1;
        check_reset_state("mid_reset");
        m_out = '{31, 31, 31, 31};
        m_dv = 0;
        @(negedge clock);
        reset = 1'b0;
        predict(4'b1110, glyph_of[3], 30, cyc);
        repeat (30) @(negedge clock);
        drain();
        check("post_reset_out0", out0, 3);
        check("post_reset_valid", digit_valid, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
